// File: rtl/cosim_commit_if.sv
// Harness-side signal bundle for the co-simulation commit checker: DUT retire stream,
// golden-model reference stream, core memory writes and the forced-result request.
interface cosim_commit_if;
  localparam int unsigned XLEN = 64;
  localparam int unsigned ILEN = 32;
  localparam int unsigned RW   = 5;

  logic            dut_commit_valid;
  logic [XLEN-1:0] dut_commit_pc;
  logic [ILEN-1:0] dut_commit_inst;
  logic            dut_commit_wen;
  logic [RW-1:0]   dut_commit_rd;
  logic [XLEN-1:0] dut_commit_wdata;

  logic            ref_valid;
  logic            ref_ready;
  logic [XLEN-1:0] ref_pc;
  logic [ILEN-1:0] ref_inst;
  logic            ref_wen;
  logic [RW-1:0]   ref_rd;
  logic [XLEN-1:0] ref_wdata;

  logic            mem_wr_valid;
  logic [XLEN-1:0] mem_wr_addr;
  logic [XLEN-1:0] mem_wr_data;

  logic            set_tohost_valid;
  logic [XLEN-1:0] set_tohost_value;

  modport master (
    output dut_commit_valid, dut_commit_pc, dut_commit_inst,
           dut_commit_wen, dut_commit_rd, dut_commit_wdata,
    output ref_valid, ref_pc, ref_inst, ref_wen, ref_rd, ref_wdata,
    input  ref_ready,
    output mem_wr_valid, mem_wr_addr, mem_wr_data,
    output set_tohost_valid, set_tohost_value
  );

  modport slave (
    input  dut_commit_valid, dut_commit_pc, dut_commit_inst,
           dut_commit_wen, dut_commit_rd, dut_commit_wdata,
    input  ref_valid, ref_pc, ref_inst, ref_wen, ref_rd, ref_wdata,
    output ref_ready,
    input  mem_wr_valid, mem_wr_addr, mem_wr_data,
    input  set_tohost_valid, set_tohost_value
  );
endinterface

// File: rtl/cosim_commit_checker.sv
// Lock-step commit checker: queues retired DUT instructions, compares them against the
// reference stream and reports the round result in a sticky tohost word.
// Optional macro COSIM_COMMIT_COUNT_EN adds a matched-commit counter output.
module cosim_commit_checker #(
  parameter logic [63:0] TOHOST_ADDR = 64'h0000_0000_8000_1000,
  parameter int unsigned FIFO_DEPTH  = 8
) (
  input  logic          clock,
  input  logic          reset,
  cosim_commit_if.slave bus,
  output logic [63:0]   tohost
`ifdef COSIM_COMMIT_COUNT_EN
  ,
  output logic [63:0]   commit_count
`endif
);
  localparam int unsigned XLEN  = 64;
  localparam int unsigned ILEN  = 32;
  localparam int unsigned RW    = 5;
  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [XLEN-1:0] RES_PC   = XLEN'(3);
  localparam logic [XLEN-1:0] RES_INST = XLEN'(7);
  localparam logic [XLEN-1:0] RES_WB   = XLEN'(9);
  localparam logic [XLEN-1:0] RES_OVF  = XLEN'(11);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] inst;
    logic            wen;
    logic [RW-1:0]   rd;
    logic [XLEN-1:0] wdata;
  } commit_t;

  commit_t          fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  logic             done_c;
  logic             empty_c;
  logic             full_c;
  logic             push_c;
  logic             pop_c;
  logic             wr_en_c;
  logic             overflow_c;
  logic             mbox_pass_c;
  commit_t          in_c;
  commit_t          head_c;
  commit_t          ref_ent_c;
  logic             pc_mis_c;
  logic             inst_mis_c;
  logic             wb_mis_c;
  logic             mis_c;
  logic [XLEN-1:0]  tohost_nxt_c;

  // Queue status and handshake qualifiers; nothing moves once the round has finished.
  always_comb begin
    done_c      = tohost[0];
    empty_c     = (count == '0);
    full_c      = (count == CNT_W'(FIFO_DEPTH));
    push_c      = bus.dut_commit_valid && !done_c;
    pop_c       = bus.ref_valid && !done_c && !empty_c;
    wr_en_c     = push_c && (!full_c || pop_c);
    overflow_c  = push_c && full_c && !pop_c;
    mbox_pass_c = bus.mem_wr_valid && (bus.mem_wr_addr == TOHOST_ADDR) && bus.mem_wr_data[0];
  end

  assign bus.ref_ready = !done_c && !empty_c;

  always_comb begin
    in_c.pc    = bus.dut_commit_pc;
    in_c.inst  = bus.dut_commit_inst;
    in_c.wen   = bus.dut_commit_wen;
    in_c.rd    = bus.dut_commit_rd;
    in_c.wdata = bus.dut_commit_wdata;

    ref_ent_c.pc    = bus.ref_pc;
    ref_ent_c.inst  = bus.ref_inst;
    ref_ent_c.wen   = bus.ref_wen;
    ref_ent_c.rd    = bus.ref_rd;
    ref_ent_c.wdata = bus.ref_wdata;

    head_c = fifo_mem[rd_ptr];
  end

  // Head-vs-reference comparison; rd/wdata only matter when both sides write, x0 ignores data.
  always_comb begin
    pc_mis_c   = (head_c.pc != ref_ent_c.pc);
    inst_mis_c = (head_c.inst != ref_ent_c.inst);
    wb_mis_c   = 1'b0;
    if (head_c.wen != ref_ent_c.wen) begin
      wb_mis_c = 1'b1;
    end else if (head_c.wen) begin
      wb_mis_c = (head_c.rd != ref_ent_c.rd) ||
                 ((head_c.rd != '0) && (head_c.wdata != ref_ent_c.wdata));
    end
    mis_c = pop_c && (pc_mis_c || inst_mis_c || wb_mis_c);
  end

  // Result selection: forced value beats mismatch beats overflow beats mailbox pass.
  always_comb begin
    tohost_nxt_c = tohost;
    if (!done_c) begin
      if (bus.set_tohost_valid) begin
        tohost_nxt_c = bus.set_tohost_value | XLEN'(1);
      end else if (mis_c) begin
        if (pc_mis_c) begin
          tohost_nxt_c = RES_PC;
        end else if (inst_mis_c) begin
          tohost_nxt_c = RES_INST;
        end else begin
          tohost_nxt_c = RES_WB;
        end
      end else if (overflow_c) begin
        tohost_nxt_c = RES_OVF;
      end else if (mbox_pass_c) begin
        tohost_nxt_c = bus.mem_wr_data;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      tohost <= '0;
    end else begin
      tohost <= tohost_nxt_c;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en_c) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop_c) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (wr_en_c && !pop_c) begin
        count <= count + CNT_W'(1);
      end else if (!wr_en_c && pop_c) begin
        count <= count - CNT_W'(1);
      end
    end
  end

  // Payload storage needs no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clock) begin
    if (wr_en_c) begin
      fifo_mem[wr_ptr] <= in_c;
    end
  end

`ifdef COSIM_COMMIT_COUNT_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      commit_count <= '0;
    end else if (pop_c && !mis_c) begin
      commit_count <= commit_count + 64'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cosim_commit_checker.sv
// Scoreboard bench for cosim_commit_checker: directed scenarios plus randomized rounds,
// each cycle scored against a queue-based reference model of the checker rules.
module tb_cosim_commit_checker;
  localparam logic [63:0] TOHOST     = 64'h0000_0000_8000_1000;
  localparam int          FIFO_DEPTH = 8;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
    logic        wen;
    logic [4:0]  rd;
    logic [63:0] wdata;
  } rec_t;

  typedef struct {
    logic        rst;
    logic        cv;
    rec_t        crec;
    logic        rv;
    rec_t        rrec;
    logic        mv;
    logic [63:0] ma;
    logic [63:0] md;
    logic        sv;
    logic [63:0] sval;
  } stim_t;

  typedef struct {
    logic        ready;
    logic [63:0] tohost;
    logic [63:0] count;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] tohost;
`ifdef COSIM_COMMIT_COUNT_EN
  logic [63:0] commit_count;
`endif

  cosim_commit_if bus ();

  always #5 clock = ~clock;

  cosim_commit_checker #(
    .TOHOST_ADDR (TOHOST),
    .FIFO_DEPTH  (FIFO_DEPTH)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .bus    (bus),
    .tohost (tohost)
`ifdef COSIM_COMMIT_COUNT_EN
    ,
    .commit_count (commit_count)
`endif
  );

  int          checks   = 0;
  int          failures = 0;
  exp_t        sb[$];
  rec_t        m_q[$];
  logic [63:0] m_tohost = '0;
  logic [63:0] m_count  = '0;

  function automatic int code_of(rec_t d, rec_t r);
    if (d.pc != r.pc) return 1;
    if (d.inst != r.inst) return 3;
    if (d.wen != r.wen) return 4;
    if (d.wen) begin
      if (d.rd != r.rd) return 4;
      if (d.rd != 5'd0 && d.wdata != r.wdata) return 4;
    end
    return 0;
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s.rst = 1'b0; s.cv = 1'b0; s.crec = '0; s.rv = 1'b0; s.rrec = '0;
    s.mv = 1'b0; s.ma = '0; s.md = '0; s.sv = 1'b0; s.sval = '0;
    return s;
  endfunction

  function automatic rec_t mk(logic [63:0] pc, logic wen, logic [4:0] rd, logic [63:0] wd);
    rec_t r;
    r.pc = pc; r.inst = 32'h0000_0013; r.wen = wen; r.rd = rd; r.wdata = wd;
    return r;
  endfunction

  function automatic rec_t rand_rec(logic [63:0] pc);
    rec_t r;
    r.pc    = pc;
    r.inst  = $urandom;
    r.wen   = 1'($urandom_range(0, 1));
    r.rd    = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
    r.wdata = {$urandom, $urandom};
    return r;
  endfunction

  function automatic rec_t corrupt(rec_t r);
    rec_t c = r;
    case ($urandom_range(0, 4))
      0:       c.pc    = r.pc ^ 64'h4;
      1:       c.inst  = r.inst ^ (32'h1 << $urandom_range(0, 31));
      2:       c.wen   = ~r.wen;
      3:       c.rd    = r.rd + 5'd1;
      default: c.wdata = ~r.wdata;
    endcase
    return c;
  endfunction

  // Drive one cycle of stimulus and push the model's expectation for it.
  task automatic step(input stim_t s);
    exp_t e;
    int   code;
    logic pop;
    logic ovf;
    @(negedge clock);
    reset                 = s.rst;
    bus.dut_commit_valid  = s.cv;
    bus.dut_commit_pc     = s.crec.pc;
    bus.dut_commit_inst   = s.crec.inst;
    bus.dut_commit_wen    = s.crec.wen;
    bus.dut_commit_rd     = s.crec.rd;
    bus.dut_commit_wdata  = s.crec.wdata;
    bus.ref_valid         = s.rv;
    bus.ref_pc            = s.rrec.pc;
    bus.ref_inst          = s.rrec.inst;
    bus.ref_wen           = s.rrec.wen;
    bus.ref_rd            = s.rrec.rd;
    bus.ref_wdata         = s.rrec.wdata;
    bus.mem_wr_valid      = s.mv;
    bus.mem_wr_addr       = s.ma;
    bus.mem_wr_data       = s.md;
    bus.set_tohost_valid  = s.sv;
    bus.set_tohost_value  = s.sval;

    e.ready = !m_tohost[0] && (m_q.size() != 0);
    if (s.rst) begin
      m_q.delete();
      m_tohost = '0;
      m_count  = '0;
    end else if (!m_tohost[0]) begin
      pop  = s.rv && e.ready;
      code = pop ? code_of(m_q[0], s.rrec) : 0;
      ovf  = s.cv && (m_q.size() == FIFO_DEPTH) && !pop;
      if (s.sv) m_tohost = s.sval | 64'd1;
      else if (code != 0) m_tohost = 64'(code * 2 + 1);
      else if (ovf) m_tohost = 64'd11;
      else if (s.mv && s.ma == TOHOST && s.md[0]) m_tohost = s.md;
      if (pop) begin
        void'(m_q.pop_front());
        if (code == 0) m_count = m_count + 64'd1;
      end
      if (s.cv && !ovf) m_q.push_back(s.crec);
    end
    e.tohost = m_tohost;
    e.count  = m_count;
    sb.push_back(e);
  endtask

  task automatic reset_round();
    stim_t s = idle();
    s.rst = 1'b1;
    step(s);
    step(idle());
  endtask

  // Monitor: ref_ready is checked late in the driven cycle, tohost just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      #2;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        checks++;
        if (bus.ref_ready !== e.ready) begin
          failures++;
          $display("FAIL ref_ready t=%0t got=%b exp=%b", $time, bus.ref_ready, e.ready);
        end
        @(posedge clock);
        #1;
        checks++;
        if (tohost !== e.tohost) begin
          failures++;
          $display("FAIL tohost t=%0t got=%h exp=%h", $time, tohost, e.tohost);
        end
`ifdef COSIM_COMMIT_COUNT_EN
        checks++;
        if (commit_count !== e.count) begin
          failures++;
          $display("FAIL commit_count t=%0t got=%0d exp=%0d", $time, commit_count, e.count);
        end
`endif
      end
    end
  end

  initial begin
    stim_t       s;
    logic [63:0] pc;
    int          p_commit;
    int          p_ref;
    int          cyc;
    int          r;

    s = idle();
    bus.dut_commit_valid = 1'b0; bus.dut_commit_pc = '0; bus.dut_commit_inst = '0;
    bus.dut_commit_wen = 1'b0; bus.dut_commit_rd = '0; bus.dut_commit_wdata = '0;
    bus.ref_valid = 1'b0; bus.ref_pc = '0; bus.ref_inst = '0; bus.ref_wen = 1'b0;
    bus.ref_rd = '0; bus.ref_wdata = '0; bus.mem_wr_valid = 1'b0; bus.mem_wr_addr = '0;
    bus.mem_wr_data = '0; bus.set_tohost_valid = 1'b0; bus.set_tohost_value = '0;

    s.rst = 1'b1;
    step(s);
    step(s);

    // Matching streams then mailbox pass.
    for (int i = 0; i < 3; i++) begin
      s = idle(); s.cv = 1'b1; s.crec = mk(64'h8000_0000 + 64'(4 * i), 1'b1, 5'd1, 64'(i)); step(s);
    end
    for (int i = 0; i < 3; i++) begin
      s = idle(); s.rv = 1'b1; s.rrec = mk(64'h8000_0000 + 64'(4 * i), 1'b1, 5'd1, 64'(i)); step(s);
    end
    s = idle(); s.mv = 1'b1; s.ma = TOHOST; s.md = 64'd1; step(s);
    step(idle());
    reset_round();

    // PC mismatch on second pop; later pass ignored.
    s = idle(); s.cv = 1'b1; s.crec = mk(64'h8000_0000, 1'b1, 5'd1, 64'd0); step(s);
    s = idle(); s.cv = 1'b1; s.crec = mk(64'h8000_0008, 1'b1, 5'd1, 64'd0); step(s);
    s = idle(); s.rv = 1'b1; s.rrec = mk(64'h8000_0000, 1'b1, 5'd1, 64'd0); step(s);
    s = idle(); s.rv = 1'b1; s.rrec = mk(64'h8000_0004, 1'b1, 5'd1, 64'd0); step(s);
    s = idle(); s.mv = 1'b1; s.ma = TOHOST; s.md = 64'd1; step(s);
    step(idle());
    reset_round();

    // Writeback mismatch on rd=5, then rd=0 differing data is accepted.
    s = idle(); s.cv = 1'b1; s.crec = mk(64'h8000_0000, 1'b1, 5'd5, 64'd1); step(s);
    s = idle(); s.rv = 1'b1; s.rrec = mk(64'h8000_0000, 1'b1, 5'd5, 64'd2); step(s);
    step(idle());
    reset_round();
    s = idle(); s.cv = 1'b1; s.crec = mk(64'h8000_0000, 1'b1, 5'd0, 64'd1); step(s);
    s = idle(); s.rv = 1'b1; s.rrec = mk(64'h8000_0000, 1'b1, 5'd0, 64'd2); step(s);
    s = idle(); s.mv = 1'b1; s.ma = TOHOST; s.md = 64'd1; step(s);
    step(idle());
    reset_round();

    // Overflow with the reference stalled.
    for (int i = 0; i < FIFO_DEPTH + 1; i++) begin
      s = idle(); s.cv = 1'b1; s.crec = mk(64'h8000_0000 + 64'(4 * i), 1'b0, 5'd0, 64'd0); step(s);
    end
    step(idle());
    reset_round();

    // Forced timeout coinciding with a pc mismatch, then reset.
    s = idle(); s.cv = 1'b1; s.crec = mk(64'h8000_0000, 1'b1, 5'd1, 64'd0); step(s);
    s = idle(); s.rv = 1'b1; s.rrec = mk(64'h8000_0004, 1'b1, 5'd1, 64'd0);
    s.sv = 1'b1; s.sval = 64'd5; step(s);
    step(idle());
    reset_round();

    // Mailbox writes that must not finish the round.
    s = idle(); s.mv = 1'b1; s.ma = TOHOST; s.md = 64'h10; step(s);
    s = idle(); s.mv = 1'b1; s.ma = TOHOST + 64'd8; s.md = 64'd1; step(s);
    step(idle());
    reset_round();

    // Randomized rounds.
    pc = 64'h8000_0000;
    for (int rnd = 0; rnd < 40; rnd++) begin
      p_commit = $urandom_range(30, 90);
      p_ref    = $urandom_range(20, 95);
      cyc      = 0;
      while (cyc < 150 && !m_tohost[0]) begin
        s = idle();
        s.cv   = ($urandom_range(0, 99) < p_commit);
        s.crec = rand_rec(pc);
        pc     = pc + 64'd4;
        s.rv   = ($urandom_range(0, 99) < p_ref);
        if (m_q.size() != 0) begin
          s.rrec = ($urandom_range(0, 19) == 0) ? corrupt(m_q[0]) : m_q[0];
        end else begin
          s.rrec = rand_rec(pc);
        end
        r = $urandom_range(0, 199);
        if (r == 0) begin
          s.mv = 1'b1; s.ma = TOHOST; s.md = {$urandom, $urandom} | 64'd1;
        end else if (r == 1) begin
          s.mv = 1'b1; s.ma = TOHOST; s.md = {$urandom, $urandom} & ~64'd1;
        end else if (r == 2) begin
          s.mv = 1'b1; s.ma = TOHOST + 64'd8; s.md = 64'd1;
        end
        if ($urandom_range(0, 399) == 0) begin
          s.sv = 1'b1; s.sval = {$urandom, $urandom};
        end
        step(s);
        cyc++;
      end
      for (int k = 0; k < 3; k++) begin
        s = idle(); s.cv = 1'b1; s.crec = rand_rec(pc); s.rv = 1'b1; s.rrec = rand_rec(pc);
        s.mv = 1'b1; s.ma = TOHOST; s.md = 64'd1; s.sv = 1'b1; s.sval = 64'd5;
        step(s);
      end
      reset_round();
    end

    repeat (3) @(negedge clock);
    #4;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain left=%0d exp=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cosim_commit_checker.md
Name: cosim_commit_checker

Overview:
- Lock-step co-simulation checker in the verification harness.
- Compares the core's retired-instruction stream against a golden-model reference stream.
- Watches memory writes to the tohost mailbox.
- Drives a sticky 64-bit tohost word that the bench polls: bit0=1 means the round is finished; the upper bits carry the result code.

Parameters:
- TOHOST_ADDR, 64'h0000_0000_8000_1000, byte address of the tohost mailbox.
- FIFO_DEPTH, 8, DUT commit queue entries; power of two, minimum 2.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- dut_commit_valid  in  1  core retires one instruction this cycle
- dut_commit_pc  in  64  retired PC
- dut_commit_inst  in  32  retired instruction word
- dut_commit_wen  in  1  retired instruction writes an integer register
- dut_commit_rd  in  5  destination register
- dut_commit_wdata  in  64  writeback value
- ref_valid  in  1  reference entry available
- ref_ready  out  1  checker consumes the reference entry this cycle
- ref_pc, ref_inst, ref_wen, ref_rd, ref_wdata  in  64/32/1/5/64  reference fields
- mem_wr_valid  in  1  core memory write
- mem_wr_addr  in  64  write address
- mem_wr_data  in  64  write data
- set_tohost_valid  in  1  external forced result, e.g. timeout
- set_tohost_value  in  64  forced tohost value
- tohost  out  64  result mailbox, registered

Behaviour:
- Reset values: tohost=0, FIFO empty, done=0, ref_ready=0.
- done = tohost[0]. Once done=1, tohost holds until reset, and all inputs are ignored.
- Commit queue: a DUT commit is pushed when dut_commit_valid && !done.
- Simultaneous push and pop when the queue is full is legal.
- ref_ready = !done && queue non-empty (combinational). Pop happens when ref_valid && ref_ready.
- On pop, compare the head entry with the ref fields in the same cycle:
  - PC differs -> code 1
  - else instruction differs -> code 3
  - else writeback differs -> code 4
- Writeback comparison:
  - Differs if wen differs.
  - When both wen=1: differs if rd differs, or if rd!=0 and wdata differs.
  - When both wen=0, rd and wdata are don't-care.
  - A write to x0 never compares wdata.
- Overflow: push while the queue is full with no pop in the same cycle -> code 5.
- Mailbox write: mem_wr_valid && mem_wr_addr==TOHOST_ADDR && mem_wr_data[0]==1 -> tohost=mem_wr_data.
  - Data 1 means pass.
  - Writes with bit0=0 are ignored.
- Error encoding: tohost = {code,1'b1}, i.e. code<<1|1:
  - pc mismatch = 3
  - inst mismatch = 7
  - writeback mismatch = 9
  - overflow = 11
- Forced value: set_tohost_valid loads set_tohost_value with bit0 forced to 1. The bench uses value 5 for timeout.
- Priority when events coincide in one cycle: set_tohost > compare mismatch > overflow > mailbox write. The first finishing event wins; later events are ignored.
- Latency: an event in cycle N makes tohost visible in cycle N+1.
- A pop in the same cycle as a mailbox pass still checks; a mismatch overrides the pass.
- Reset mid-round: queue flushed, tohost cleared on the next edge.
- Entries still queued when done is set are discarded.

Optional Feature:
- Macro: COSIM_COMMIT_COUNT_EN.
- When defined:
  - Adds output commit_count [63:0], reset 0.
  - Increments on every successful, non-mismatching pop while !done.
  - Freezes when done=1.
- When undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Matching streams: 3 commits (pc 0x80000000/04/08, identical fields) popped, then mailbox write data 1 to TOHOST_ADDR -> tohost=1 the next cycle; commit_count=3 when COSIM_COMMIT_COUNT_EN is defined.
- Ref pc 0x80000004 vs DUT pc 0x80000008 on the second pop -> tohost=3 one cycle after the pop; a later mailbox pass leaves tohost=3.
- Same pc/inst, wen=1, rd=5, DUT wdata 0x1 vs ref 0x2 -> tohost=9; repeat with rd=0 and differing wdata -> no error.
- ref_valid held 0, FIFO_DEPTH+1 DUT commits -> ref_ready=1 after the first push; tohost=11 after the overflowing push.
- set_tohost_valid with value 5 in the same cycle as a pc mismatch -> tohost=5; assert reset for 1 cycle -> tohost=0 and queue empty.
- Mailbox write data 0x10 (bit0=0) to TOHOST_ADDR, or data 1 to TOHOST_ADDR+8 -> tohost stays 0.
